// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and width helpers for the FIFO read-side packer.
package fifo_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

  localparam int RATIO_DEF   = 4;
  localparam int TIMEOUT_DEF = 16;

  function automatic int idx_width(input int ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

  function automatic int tmr_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

  localparam int IDX_W = idx_width(RATIO_DEF);
  localparam int TMR_W = tmr_width(TIMEOUT_DEF);

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed-beat valid/ready bus; master is the packer side.
interface fifo_rd_packer_if #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
);
  logic                     i_fifo_empty;
  logic [WIDTH-1:0]         i_fifo_data;
  logic                     o_fifo_rd_en;
  logic                     i_flush;
  logic                     o_valid;
  logic                     i_ready;
  logic [WIDTH*RATIO-1:0]   o_data;
  logic [RATIO-1:0]         o_keep;
  logic                     o_last;
  logic [15:0]              o_beat_cnt;

  modport master (
    input  i_fifo_empty, i_fifo_data, i_flush, i_ready,
    output o_fifo_rd_en, o_valid, o_data, o_keep, o_last, o_beat_cnt
  );

  modport slave (
    output i_fifo_empty, i_fifo_data, i_flush, i_ready,
    input  o_fifo_rd_en, o_valid, o_data, o_keep, o_last, o_beat_cnt
  );
endinterface

// File: rtl/fifo_rd_packer_idle_timer.sv
// Idle counter for a partially filled beat; expire is a combinational pulse on
// the cycle whose incremented count reaches TIMEOUT (never fires when TIMEOUT=0).
module pack_idle_timer
  import fifo_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int TW = tmr_width(TIMEOUT);

  logic [TW-1:0] cnt;
  logic [TW:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt} + 1'b1;
  assign expire  = (TIMEOUT != 0) && enable && !clear && (cnt_inc == (TW+1)'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !enable || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_inc[TW-1:0];
    end
  end
endmodule

// File: rtl/fifo_rd_packer.sv
// Packs RATIO show-ahead FIFO words into one wide beat; partial beats close on
// idle timeout or flush and are tagged with keep/last.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              i_rd_clk,
  input  logic              i_rd_rstn,
  fifo_rd_packer_if.master  bus
);
  localparam int                  IDX_BITS = idx_width(RATIO);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(RATIO - 1);

  pack_state_e                 state;
  logic [IDX_BITS-1:0]         idx;
  logic [RATIO-1:0][WIDTH-1:0] lanes;
  logic [RATIO-1:0]            keep;
  logic                        last_q;
  logic                        valid_q;
  logic [15:0]                 beat_cnt;
  logic                        pop;
  logic                        tmr_en;
  logic                        expire;

  // Popping in HOLD is only allowed on the acceptance cycle, straight into lane 0.
  assign pop    = i_rd_rstn && !bus.i_fifo_empty && ((state == FILL) || bus.i_ready);
  assign tmr_en = (state == FILL) && (idx != '0);

  pack_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
    .clk    (i_rd_clk),
    .rst_n  (i_rd_rstn),
    .clear  (pop),
    .enable (tmr_en),
    .expire (expire)
  );

  always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
    if (!i_rd_rstn) begin
      state    <= FILL;
      idx      <= '0;
      lanes    <= '0;
      keep     <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      beat_cnt <= '0;
    end else if (state == FILL) begin
      if (pop) begin
        lanes[idx] <= bus.i_fifo_data;
        keep[idx]  <= 1'b1;
      end
      if (pop && (idx == LAST_IDX)) begin
        state   <= HOLD;
        valid_q <= 1'b1;
        last_q  <= bus.i_flush;
        idx     <= '0;
      end else if ((bus.i_flush && (pop || (idx != '0))) || expire) begin
        state   <= HOLD;
        valid_q <= 1'b1;
        last_q  <= 1'b1;
        idx     <= '0;
      end else if (pop) begin
        idx <= idx + 1'b1;
      end
    end else if (bus.i_ready) begin
      state    <= FILL;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      beat_cnt <= beat_cnt + 1'b1;
      lanes    <= '0;
      if (pop) begin
        lanes[0] <= bus.i_fifo_data;
        keep     <= RATIO'(1);
        idx      <= IDX_BITS'(1);
      end else begin
        keep <= '0;
        idx  <= '0;
      end
    end
  end

  assign bus.o_fifo_rd_en = pop;
  assign bus.o_valid      = valid_q;
  assign bus.o_data       = lanes;
  assign bus.o_keep       = keep;
  assign bus.o_last       = last_q;
  assign bus.o_beat_cnt   = beat_cnt;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a show-ahead FIFO model and beat monitor.
module tb_fifo_rd_packer;
  localparam int WIDTH   = 8;
  localparam int RATIO   = 4;
  localparam int TIMEOUT = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   cyc;
  int   pops;
  int   viol;
  int   valid_cycles;

  logic [7:0]  q[$];
  logic [31:0] beat_data[$];
  logic [3:0]  beat_keep[$];
  logic        beat_last[$];
  int          beat_cyc[$];

  fifo_rd_packer_if #(.WIDTH(WIDTH), .RATIO(RATIO)) bus ();

  fifo_rd_packer #(.WIDTH(WIDTH), .RATIO(RATIO), .TIMEOUT(TIMEOUT)) dut (
    .i_rd_clk  (clk),
    .i_rd_rstn (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void refresh();
    bus.i_fifo_empty = (q.size() == 0);
    bus.i_fifo_data  = (q.size() == 0) ? 8'h00 : q[0];
  endfunction

  task automatic push(input logic [7:0] w);
    q.push_back(w);
    refresh();
  endtask

  // FIFO model: pop on the edge, present the new head shortly after.
  always @(posedge clk) begin
    cyc++;
    if (bus.o_fifo_rd_en) begin
      if (q.size() == 0) viol++;
      else void'(q.pop_front());
      pops++;
    end
    if (bus.o_valid) valid_cycles++;
    if (bus.o_valid && bus.i_ready) begin
      beat_data.push_back(bus.o_data);
      beat_keep.push_back(bus.o_keep);
      beat_last.push_back(bus.o_last);
      beat_cyc.push_back(cyc);
    end
    #1 refresh();
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_flush = 1'b0;
    push(8'h5A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.o_fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", bus.o_fifo_rd_en); end
      n_checks++;
      if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
      n_checks++;
      if (bus.o_keep !== 4'h0) begin n_fail++; $display("FAIL reset_keep: got %h want 0", bus.o_keep); end
      n_checks++;
      if (bus.o_beat_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.o_beat_cnt); end
    end
    q.delete();
    refresh();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_beat();
    int n;
    n = beat_data.size();
    bus.i_ready = 1'b1;
    valid_cycles = 0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    for (int i = 0; i < 20 && beat_data.size() < n + 1; i++) @(negedge clk);
    n_checks++;
    if (beat_data.size() != n + 1) begin
      n_fail++; $display("FAIL full_beat_count: got %0d want %0d", beat_data.size(), n + 1);
    end else begin
      n_checks++;
      if (beat_data[n] !== 32'h44332211) begin n_fail++; $display("FAIL full_data: got %h want 44332211", beat_data[n]); end
      n_checks++;
      if (beat_keep[n] !== 4'hF) begin n_fail++; $display("FAIL full_keep: got %h want f", beat_keep[n]); end
      n_checks++;
      if (beat_last[n] !== 1'b0) begin n_fail++; $display("FAIL full_last: got %b want 0", beat_last[n]); end
    end
    @(negedge clk);
    n_checks++;
    if (valid_cycles != 1) begin n_fail++; $display("FAIL full_valid_cycles: got %0d want 1", valid_cycles); end
    n_checks++;
    if (bus.o_beat_cnt !== 16'd1) begin n_fail++; $display("FAIL full_cnt: got %0d want 1", bus.o_beat_cnt); end
  endtask

  task automatic test_back_to_back();
    int n;
    int p0;
    bit stable;
    n  = beat_data.size();
    p0 = pops;
    stable = 1'b1;
    bus.i_ready = 1'b0;
    for (int w = 1; w <= 8; w++) push(8'(w * 8'h11));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 4 && (bus.o_valid !== 1'b1 || bus.o_data !== 32'h44332211)) stable = 1'b0;
    end
    n_checks++;
    if (!stable) begin n_fail++; $display("FAIL bp_stable: valid=%b data=%h want 1/44332211", bus.o_valid, bus.o_data); end
    n_checks++;
    if (pops - p0 != 4) begin n_fail++; $display("FAIL bp_pops: got %0d want 4", pops - p0); end
    bus.i_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pops - p0 != 5) begin n_fail++; $display("FAIL bp_accept_pop: got %0d want 5", pops - p0); end
    for (int i = 0; i < 20 && beat_data.size() < n + 2; i++) @(negedge clk);
    n_checks++;
    if (beat_data.size() != n + 2) begin
      n_fail++; $display("FAIL bp_beat_count: got %0d want %0d", beat_data.size(), n + 2);
    end else begin
      n_checks++;
      if (beat_data[n] !== 32'h44332211) begin n_fail++; $display("FAIL bp_first_data: got %h want 44332211", beat_data[n]); end
      n_checks++;
      if (beat_data[n+1] !== 32'h88776655) begin n_fail++; $display("FAIL bp_second_data: got %h want 88776655", beat_data[n+1]); end
      n_checks++;
      if (beat_keep[n+1] !== 4'hF || beat_last[n+1] !== 1'b0) begin
        n_fail++; $display("FAIL bp_second_flags: keep=%h last=%b want f/0", beat_keep[n+1], beat_last[n+1]);
      end
      n_checks++;
      if (beat_cyc[n+1] - beat_cyc[n] != 4) begin
        n_fail++; $display("FAIL bp_spacing: got %0d want 4", beat_cyc[n+1] - beat_cyc[n]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus.o_beat_cnt !== 16'd3) begin n_fail++; $display("FAIL bp_cnt: got %0d want 3", bus.o_beat_cnt); end
  endtask

  task automatic test_timeout();
    int n;
    n = beat_data.size();
    bus.i_ready = 1'b1;
    push(8'hA1); push(8'hB2);
    repeat (2) @(negedge clk);
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL to_early: valid got %b want 0", bus.o_valid); end
    @(negedge clk);
    n_checks++;
    if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL to_rise: valid got %b want 1", bus.o_valid); end
    @(negedge clk);
    n_checks++;
    if (beat_data.size() != n + 1) begin
      n_fail++; $display("FAIL to_beat_count: got %0d want %0d", beat_data.size(), n + 1);
    end else begin
      n_checks++;
      if (beat_data[n] !== 32'h0000B2A1) begin n_fail++; $display("FAIL to_data: got %h want 0000b2a1", beat_data[n]); end
      n_checks++;
      if (beat_keep[n] !== 4'h3) begin n_fail++; $display("FAIL to_keep: got %h want 3", beat_keep[n]); end
      n_checks++;
      if (beat_last[n] !== 1'b1) begin n_fail++; $display("FAIL to_last: got %b want 1", beat_last[n]); end
    end
  endtask

  task automatic test_flush();
    int n;
    n = beat_data.size();
    bus.i_ready = 1'b1;
    push(8'h01); push(8'h02); push(8'h03);
    repeat (3) @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    n_checks++;
    if (bus.o_valid !== 1'b1 || bus.o_keep !== 4'h7) begin
      n_fail++; $display("FAIL fl_rise: valid=%b keep=%h want 1/7", bus.o_valid, bus.o_keep);
    end
    @(negedge clk);
    n_checks++;
    if (beat_data.size() != n + 1) begin
      n_fail++; $display("FAIL fl_beat_count: got %0d want %0d", beat_data.size(), n + 1);
    end else begin
      n_checks++;
      if (beat_data[n] !== 32'h00030201) begin n_fail++; $display("FAIL fl_data: got %h want 00030201", beat_data[n]); end
      n_checks++;
      if (beat_last[n] !== 1'b1) begin n_fail++; $display("FAIL fl_last: got %b want 1", beat_last[n]); end
    end
    n_checks++;
    if (bus.o_beat_cnt !== 16'd5) begin n_fail++; $display("FAIL fl_cnt: got %0d want 5", bus.o_beat_cnt); end
  endtask

  task automatic test_flush_idle();
    int n;
    n = beat_data.size();
    valid_cycles = 0;
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (beat_data.size() != n || valid_cycles != 0) begin
      n_fail++; $display("FAIL fl_idle: beats=%0d valid_cycles=%0d want %0d/0", beat_data.size(), valid_cycles, n);
    end
  endtask

  task automatic test_reset_hold();
    int n;
    bus.i_ready = 1'b0;
    push(8'h10); push(8'h20); push(8'h30); push(8'h40);
    for (int i = 0; i < 20 && bus.o_valid !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL rh_hold: valid got %b want 1", bus.o_valid); end
    n = beat_data.size();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rh_valid_drop: got %b want 0", bus.o_valid); end
    n_checks++;
    if (bus.o_beat_cnt !== 16'd0) begin n_fail++; $display("FAIL rh_cnt_clear: got %0d want 0", bus.o_beat_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    for (int i = 0; i < 20 && beat_data.size() < n + 1; i++) @(negedge clk);
    n_checks++;
    if (beat_data.size() != n + 1) begin
      n_fail++; $display("FAIL rh_beat_count: got %0d want %0d", beat_data.size(), n + 1);
    end else begin
      n_checks++;
      if (beat_data[n] !== 32'hC4C3C2C1) begin n_fail++; $display("FAIL rh_data: got %h want c4c3c2c1", beat_data[n]); end
      n_checks++;
      if (beat_keep[n] !== 4'hF || beat_last[n] !== 1'b0) begin
        n_fail++; $display("FAIL rh_flags: keep=%h last=%b want f/0", beat_keep[n], beat_last[n]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus.o_beat_cnt !== 16'd1) begin n_fail++; $display("FAIL rh_cnt: got %0d want 1", bus.o_beat_cnt); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    pops     = 0;
    viol     = 0;
    valid_cycles = 0;
    rst_n       = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_flush = 1'b0;
    refresh();
    test_reset();
    test_full_beat();
    test_back_to_back();
    test_timeout();
    test_flush();
    test_flush_idle();
    test_reset_hold();
    n_checks++;
    if (viol != 0) begin n_fail++; $display("FAIL pop_while_empty: got %0d want 0", viol); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side width packer placed directly downstream of the async FIFO, in the read clock domain. It pops show-ahead words from the FIFO read port and packs RATIO consecutive words into one wide beat. Each beat is presented on a valid/ready interface. A beat that cannot be completed is emitted as a partial beat, marked by keep and last, on either an idle timeout or an explicit flush.

## Interface
- WIDTH, 8: FIFO word width in bits.
- RATIO, 4: words per output beat; must be ≥2.
- TIMEOUT, 16: number of idle cycles with a partial beat before it is emitted; 0 disables the timeout.

Ports:
- i_rd_clk  in  1  read-domain clock; the only clock in the block.
- i_rd_rstn  in  1  reset, asynchronous assert, active-low.
- i_fifo_empty  in  1  FIFO empty flag. When low, i_fifo_data holds the head word (show-ahead).
- i_fifo_data  in  WIDTH  FIFO head word.
- o_fifo_rd_en  out  1  pop strobe. Combinational; only ever asserted while i_fifo_empty=0.
- i_flush  in  1  single-cycle request to emit the current partial beat.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream ready.
- o_data  out  WIDTH*RATIO  packed beat. Lane k is o_data[k*WIDTH +: WIDTH]; lane 0 holds the first-popped word.
- o_keep  out  RATIO  per-lane valid mask.
- o_last  out  1  beat was closed by timeout or flush.
- o_beat_cnt  out  16  count of accepted beats; wraps modulo 2^16.

## Operation
States: FILL and HOLD. Reset state is FILL with lane index idx=0.

FILL:
- o_fifo_rd_en = ~i_fifo_empty.
- A pop writes i_fifo_data into lane idx, sets keep[idx], and increments idx.
- A pop with idx=RATIO-1 completes the beat: go to HOLD with keep all ones, o_last=0.

Idle timer (only while in FILL with idx>0):
- Cleared on every pop.
- Otherwise incremented by 1 each cycle.
- When the incremented value equals TIMEOUT (TIMEOUT≠0): go to HOLD with the current keep and o_last=1.

Flush:
- i_flush with idx>0 in FILL: go to HOLD with o_last=1.
- If a pop happens in the same cycle, that word is included in the beat first.
- If that pop also completes the beat, the beat is full with o_last=1.
- i_flush with idx=0 and no pop: ignored.
- i_flush in HOLD: ignored.

HOLD:
- o_valid=1, and o_data, o_keep and o_last are stable until the handshake.
- o_fifo_rd_en=0 unless i_ready=1.
- On o_valid & i_ready:
  - o_beat_cnt increments.
  - Return to FILL with idx=0, keep=0, and all lanes cleared to 0.
  - If i_fifo_empty=0 in the same cycle, pop into lane 0, giving idx=1 on the next cycle.

General rules:
- Unfilled lanes read 0.
- idx and the timer widths follow the package constants.

## Timing
Reset values (async, immediate):
- o_valid=0, o_data=0, o_keep=0, o_last=0, o_beat_cnt=0.
- o_fifo_rd_en is forced to 0 while i_rd_rstn=0.

Latency and throughput:
- A completing pop at edge e gives o_valid=1 after edge e.
- With the FIFO never empty and i_ready held high, throughput is one beat per RATIO cycles.

Timeout:
- Last pop at edge e, and no pops at edges e+1..e+TIMEOUT: o_valid rises after edge e+TIMEOUT.

Flush:
- i_flush sampled at edge e: o_valid rises after edge e.

Other boundary conditions:
- An FIFO empty flag that deasserts late only delays pops; the block never pops while i_fifo_empty=1.
- Reset during HOLD drops o_valid immediately. The held beat is discarded and is not counted.

## Structure
Shared package fifo_pkg holds:
- The state enum (FILL, HOLD).
- IDX_W = $clog2(RATIO).
- TMR_W = $clog2(TIMEOUT+1), with a minimum of 1.

One sub-module is natural: pack_idle_timer.
- Inputs: clear (pop), enable (FILL & idx>0).
- Output: expire pulse.
- Reset to 0, asynchronous active-low.

## Test plan
All scenarios use WIDTH=8, RATIO=4, TIMEOUT=4.
- Reset with the FIFO non-empty -> o_fifo_rd_en=0, o_valid=0, o_keep=0, o_beat_cnt=0 throughout reset.
- FIFO holds 0x11,0x22,0x33,0x44 and i_ready=1 -> one beat with o_data=0x44332211, o_keep=4'hF, o_last=0, o_valid high for exactly 1 cycle, o_beat_cnt=1.
- FIFO holds 8 words 0x11..0x88 and i_ready=0 for 10 cycles -> o_valid held with o_data stable at 0x44332211, exactly 4 pops. After i_ready=1: lane 0 is popped on the acceptance cycle, then a second beat 0x88776655 appears 4 cycles later.
- FIFO holds 0xA1,0xB2 and then stays empty -> after 4 idle edges: o_data=0x0000B2A1, o_keep=4'h3, o_last=1.
- Flush cases:
  - 3 words 0x01,0x02,0x03, then an i_flush pulse -> o_data=0x00030201, o_keep=4'h7, o_last=1.
  - i_flush pulse with idx=0 -> no beat is emitted.
- Reset asserted mid-HOLD, then 4 new words -> o_valid drops immediately and o_beat_cnt=0. The next beat contains only the new words.
